// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch front end.
// FETCH_PERF_EN enables the performance counters in fetch_pc_unit.
package fetch_pkg;
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam int unsigned RESET_PC_DEF  = 0;
  localparam int unsigned MEM_WORDS_DEF = 128;
endpackage

// File: rtl/fetch_hold_buf.sv
// Stall capture register: instruction, PC and valid flag.
// Clear has priority over load.
module fetch_hold_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [31:0]       i_inst,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_valid
);
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_inst  <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_inst  <= i_inst;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: PC, stall hold buffer, redirect squash, halt.
// Define FETCH_PERF_EN to add perf_fetched / perf_squashed.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int RESET_PC  = RESET_PC_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [15:0]       perf_squashed
`endif
);
  localparam logic [ADDR_W-1:0] LP_END = ADDR_W'(MEM_WORDS);
  localparam logic [ADDR_W-1:0] LP_RST = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LP_ONE = ADDR_W'(1);

  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_pc_d1;
  logic              r_valid_d1;
  logic              w_vd1_run, w_vd1_nxt;
  logic              w_load, w_clear, w_in_range;
  logic [31:0]       w_buf_inst;
  logic [ADDR_W-1:0] w_buf_pc;
  logic              w_buf_valid;

  assign w_in_range = (r_pc < LP_END);

  // w_vd1_run: word latched this edge would be valid absent a redirect
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_vd1_run   = 1'b0;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (stall && r_valid_d1) begin
          w_load      = 1'b1;
          w_state_nxt = ST_HOLD;
          w_vd1_run   = w_in_range;
        end else if (!w_in_range) begin
          w_state_nxt = ST_HALTED;
        end else if (!stall) begin
          w_pc_nxt  = r_pc + LP_ONE;
          w_vd1_run = 1'b1;
        end
      end
      ST_HOLD: begin
        if (stall) begin
          w_vd1_run = w_in_range;
        end else begin
          w_clear = 1'b1;
          if (!w_in_range) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = r_pc + LP_ONE;
            w_vd1_run   = 1'b1;
          end
        end
      end
      default: ;
    endcase
    w_vd1_nxt = w_vd1_run;
    if (redirect_valid) begin
      w_state_nxt = ST_RUN;
      w_pc_nxt    = redirect_target;
      w_vd1_nxt   = 1'b0;
      w_load      = 1'b0;
      w_clear     = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_pc       <= LP_RST;
      r_pc_d1    <= '0;
      r_valid_d1 <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pc_d1    <= r_pc;
      r_valid_d1 <= w_vd1_nxt;
    end
  end

  fetch_hold_buf #(.ADDR_W(ADDR_W)) u_hold (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_inst  (imem_inst),
    .i_pc    (r_pc_d1),
    .o_inst  (w_buf_inst),
    .o_pc    (w_buf_pc),
    .o_valid (w_buf_valid)
  );

  assign imem_addr  = r_pc;
  assign inst_out   = (r_state == ST_HOLD) ? w_buf_inst : imem_inst;
  assign inst_pc    = (r_state == ST_HOLD) ? w_buf_pc : r_pc_d1;
  assign inst_valid = (r_state == ST_HOLD) ? w_buf_valid : r_valid_d1;
  assign halted     = (r_state == ST_HALTED);

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetched;
  logic [15:0] r_squashed;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetched  <= '0;
      r_squashed <= '0;
    end else begin
      if (inst_valid && !stall && (r_fetched != '1))
        r_fetched <= r_fetched + 32'd1;
      if (redirect_valid && w_vd1_run && (r_squashed != '1))
        r_squashed <= r_squashed + 16'd1;
    end
  end

  assign perf_fetched  = r_fetched;
  assign perf_squashed = r_squashed;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random
// stall/redirect traffic against a stream-level reference model.
module tb_fetch_pc_unit;
  localparam int MW = 128;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [15:0] perf_squashed;
`endif

  always #5 clock = ~clock;

  fetch_pc_unit #(.ADDR_W(32), .MEM_WORDS(MW), .RESET_PC(0)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_inst       (imem_inst),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc),
    .inst_valid      (inst_valid),
    .halted          (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_squashed   (perf_squashed)
`endif
  );

  logic [31:0] mem [0:MW-1];

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (a < MW) return mem[a];
    return 32'hBAD0_0000 ^ a;
  endfunction

  always @(posedge clock) imem_inst <= memrd(imem_addr);

  int n_tests = 0;
  int n_fail  = 0;

  // Stream model: what is presented now, and the next word due
  bit          m_v;
  int unsigned m_pc;
  int unsigned m_nxt;
  bit          m_halt;
  int unsigned m_fet;
  int unsigned m_sq;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":valid"}, 32'(inst_valid), 32'(m_v));
    chk({ph, ":addr"}, imem_addr, m_nxt);
    chk({ph, ":halted"}, 32'(halted), 32'(m_halt));
    if (m_v) begin
      chk({ph, ":pc"}, inst_pc, m_pc);
      chk({ph, ":inst"}, inst_out, memrd(m_pc));
    end
`ifdef FETCH_PERF_EN
    chk({ph, ":perf_f"}, perf_fetched, m_fet);
    chk({ph, ":perf_s"}, 32'(perf_squashed), m_sq);
`endif
  endtask

  task automatic model_reset();
    m_v = 0; m_pc = 0; m_nxt = 0; m_halt = 0;
    m_fet = 0; m_sq = 0;
  endtask

  task automatic model_edge(input bit s, input bit r,
                            input int unsigned t);
    if (m_v && !s) m_fet++;
    if (r) begin
      if (!m_halt && m_nxt < MW && !(s && !m_v)) m_sq++;
      m_v = 0; m_nxt = t; m_halt = 0;
    end else if (m_halt) begin
    end else if (m_v && s) begin
    end else if (m_nxt >= MW) begin
      m_halt = 1; m_v = 0;
    end else if (s) begin
      m_v = 0;
    end else begin
      m_v = 1; m_pc = m_nxt; m_nxt++;
    end
  endtask

  task automatic step(input string ph, input bit s, input bit r,
                      input int unsigned t);
    check_all(ph);
    stall = s;
    redirect_valid = r;
    redirect_target = t;
    model_edge(s, r, t);
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < MW; i++) mem[i] = $urandom;
    mem[0] = 32'h0080_2820;
    mem[1] = 32'h0025_2820;
    mem[4] = 32'h00c7_402a;
    mem[5] = 32'h1500_0002;
    model_reset();

    @(negedge clock);
    @(negedge clock);
    check_all("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 20 && !(m_v && m_pc == 4); i++)
      step("run", 0, 0, 0);
    repeat (3) step("stall", 1, 0, 0);
    step("release", 0, 0, 0);
    step("after", 0, 0, 0);

    for (int i = 0; i < 20 && !(m_v && m_pc == 10); i++)
      step("run2", 0, 0, 0);
    step("redir", 0, 1, 0);
    repeat (3) step("post_redir", 0, 0, 0);

    for (int i = 0; i < 20 && !(m_v && m_pc == 3); i++)
      step("run3", 0, 0, 0);
    step("redir_stall", 1, 1, 20);
    repeat (3) step("post_rs", 0, 0, 0);

    for (int i = 0; i < 300 && !m_halt; i++)
      step("free", 0, 0, 0);
    repeat (3) step("halted", 0, 0, 0);
    step("halt_stall", 1, 0, 0);
    step("unhalt", 0, 1, 2);
    repeat (3) step("post_unhalt", 0, 0, 0);

    step("far", 0, 1, 200);
    repeat (3) step("post_far", 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      bit          s;
      bit          r;
      int unsigned t;
      s = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 19) == 0);
      t = ($urandom_range(0, 3) == 0) ? $urandom_range(115, 140)
                                      : $urandom_range(0, 127);
      step("rand", s, r, t);
    end

    step("pre_hold", 0, 1, 5);
    step("pre_hold2", 0, 0, 0);
    step("hold1", 1, 0, 0);
    step("hold2", 1, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid:valid", 32'(inst_valid), 32'(m_v));
    chk("rst_mid:addr", imem_addr, m_nxt);
    chk("rst_mid:halted", 32'(halted), 32'(m_halt));
    @(negedge clock);
    stall = 1'b0;
    redirect_valid = 1'b0;
    check_all("in_reset");
    reset_n = 1'b1;
    repeat (4) step("restart", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
